// File: rtl/sar_logic_10bit.sv
// Successive-approximation controller for a 10-bit two-step SAR ADC.
// Runs the coarse-then-fine binary search and drives the DAC mux code and phase select.
module sar_logic_10bit #(
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned COARSE_BITS   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       comp_out,
  output logic       sample,
  output logic [9:0] dac_code,
  output logic       step_fine,
  output logic       busy,
  output logic       done,
  output logic [9:0] result,
  output logic [1:0] fsm_state
);

  localparam int unsigned FINE_BITS = 10 - COARSE_BITS;
  localparam int SCW = $clog2(SAMPLE_CYCLES) + 1;
  localparam int TCW = $clog2(SETTLE_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, SAMPLE, BIT, DONE} state_t;

  state_t         state_q, state_n;
  logic [SCW-1:0] scnt_q, scnt_n;
  logic [TCW-1:0] tcnt_q, tcnt_n;
  logic [3:0]     idx_q, idx_n;
  logic [9:0]     dac_q, dac_n;
  logic [9:0]     res_q, res_n;
  logic           step_q, step_n;
  logic [9:0]     bit_mask;
  logic [9:0]     decided;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      tcnt_q  <= '0;
      idx_q   <= 4'd9;
      dac_q   <= 10'h000;
      res_q   <= 10'h000;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      scnt_q  <= scnt_n;
      tcnt_q  <= tcnt_n;
      idx_q   <= idx_n;
      dac_q   <= dac_n;
      res_q   <= res_n;
      step_q  <= step_n;
    end
  end

  // Trial bit k is already set in dac_q; the comparator only decides whether it survives.
  assign bit_mask = 10'(1) << idx_q;
  assign decided  = comp_out ? dac_q : (dac_q & ~bit_mask);

  always_comb begin
    state_n = state_q;
    scnt_n  = scnt_q;
    tcnt_n  = tcnt_q;
    idx_n   = idx_q;
    dac_n   = dac_q;
    res_n   = res_q;
    step_n  = step_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_n = SAMPLE;
          scnt_n  = '0;
          dac_n   = 10'h000;
        end
      end
      SAMPLE: begin
        if (scnt_q == SCW'(SAMPLE_CYCLES - 1)) begin
          state_n = BIT;
          idx_n   = 4'd9;
          tcnt_n  = '0;
          dac_n   = 10'h200;
          step_n  = (32'd9 < FINE_BITS);
        end else begin
          scnt_n = scnt_q + 1'b1;
        end
      end
      BIT: begin
        if (tcnt_q == TCW'(SETTLE_CYCLES)) begin
          tcnt_n = '0;
          if (idx_q == 4'd0) begin
            state_n = DONE;
            dac_n   = decided;
            res_n   = decided;
            step_n  = 1'b0;
            idx_n   = 4'd9;
          end else begin
            idx_n  = idx_q - 4'd1;
            dac_n  = decided | (10'(1) << idx_n);
            step_n = (32'(idx_n) < FINE_BITS);
          end
        end else begin
          tcnt_n = tcnt_q + 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_n = SAMPLE;
          scnt_n  = '0;
          dac_n   = 10'h000;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign sample    = (state_q == SAMPLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign dac_code  = dac_q;
  assign step_fine = step_q;
  assign result    = res_q;
  assign fsm_state = state_q;

endmodule

// File: doc/sar_logic_10bit.md
# sar_logic_10bit

Successive-approximation controller for the 10-bit two-step SAR ADC. It runs the binary search, coarse bits first and then fine bits. It drives the trial code into the 10-bit DAC-code multiplexer's input_A and produces the coarse/fine phase flag for that multiplexer's select. Each conversion is started by a single start pulse, and a completed result is reported with a one-cycle done strobe.

## Interface
- SAMPLE_CYCLES, 2: cycles the track/hold sample phase lasts (≥1)
- SETTLE_CYCLES, 1: extra DAC/comparator settle cycles per bit before the decision (≥0)
- COARSE_BITS, 5: MSBs resolved in the coarse step; the remaining 10−COARSE_BITS are fine (1..9)
- clk  input  1  single system clock; all logic is rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  conversion request, sampled on rising edge
- comp_out  input  1  comparator decision; 1 = Vin ≥ DAC (keep the bit), 0 = clear the bit
- sample  output  1  high during the sample phase (drives the T/H switch)
- dac_code  output  10  trial code to the DAC mux input_A, registered
- step_fine  output  1  0 during coarse bits, 1 during fine bits, registered; drives the mux select
- busy  output  1  high from the cycle after start is accepted until the done cycle, inclusive
- done  output  1  one-cycle pulse when the result is valid
- result  output  10  last completed conversion, held until the next done

## Operation
- States: IDLE, SAMPLE, BIT, DONE.
- Reset values:
  - State is IDLE.
  - sample, step_fine, busy and done are 0.
  - dac_code and result are 10'h000.
  - The bit index is 9 and all counters are 0.
- IDLE:
  - start=1 → SAMPLE.
  - dac_code keeps its previous value.
- SAMPLE:
  - sample=1 and dac_code=10'h000 for SAMPLE_CYCLES cycles.
  - Then → BIT with index 9.
- BIT k:
  - Each bit window lasts SETTLE_CYCLES+1 cycles.
  - On the first cycle of the window, dac_code = (decided upper bits) | (1<<k), and lower bits are 0.
  - comp_out is sampled on the edge that ends the window:
    - 1 → bit k stays set.
    - 0 → bit k is cleared.
  - Then k decrements. After k=0 → DONE.
- step_fine=1 while k < 10−COARSE_BITS; otherwise 0.
- DONE:
  - Lasts one cycle with done=1.
  - result and dac_code equal the final code.
  - step_fine returns to 0.
  - start=1 in this cycle → SAMPLE (back-to-back conversion). Otherwise → IDLE.
- start while busy is ignored outside the DONE cycle. No queuing.
- comp_out is ignored outside decision edges.
- Synchronous rst at any point, including mid-conversion, restores all reset values on that edge. The partial code is discarded and result is cleared.
- All arithmetic is 10-bit unsigned; no wrap-around is possible. Counters are sized as clog2 of their parameter + 1.

## Timing
- Count cycle 0 as the cycle in which start=1 is sampled.
- SAMPLE occupies cycles 1..SAMPLE_CYCLES.
- Bit 9 begins at cycle SAMPLE_CYCLES+1.
- done is high in cycle SAMPLE_CYCLES + 10·(SETTLE_CYCLES+1) + 1.
  - Defaults: sample in cycles 1–2, bits in cycles 3–22, done in cycle 23.
  - Defaults: step_fine=1 in cycles 13–22.
- Conversion period with back-to-back start in DONE: SAMPLE_CYCLES + 10·(SETTLE_CYCLES+1) + 1 cycles, i.e. 23 at defaults.
- result updates on the same edge that raises done. It is stable from that cycle until the next done or rst.
- The comparator path is treated as combinational from dac_code within the settle window. SETTLE_CYCLES=0 gives one cycle per bit.

## Test plan
- Ideal comparator model comp_out = (vin ≥ dac_code), vin=10'h2A5, start pulse at cycle 0 (defaults):
  - sample in cycles 1–2.
  - dac_code=10'h200 in cycle 3.
  - done only in cycle 23, result=10'h2A5, busy 1→22 high then 23 high, 24 low.
- Extremes: vin=10'h3FF gives result 10'h3FF; vin=10'h000 gives result 10'h000 with dac_code=10'h000 in the done cycle. Check step_fine=0 in cycles 3–12 and 1 in cycles 13–22.
- start re-asserted at cycles 5 and 15:
  - Ignored; a single done at cycle 23.
  - start asserted in cycle 23 starts a new conversion with sample high in cycles 24–25 and the next done at cycle 46.
- rst asserted in cycle 10 of a conversion with a previous result of 10'h123:
  - Cycle 11 has all reset values, with result=10'h000.
  - A new start then converts normally.
- Parameter sweep SAMPLE_CYCLES=1, SETTLE_CYCLES=0, COARSE_BITS=3, vin=10'h155:
  - done in cycle 12, result=10'h155.
  - step_fine high in cycles 5–11.
